// File: rtl/div_issue_unit.sv
// div_issue_unit: execute-stage wrapper around an iterative unsigned divider core.
// Takes RISC-V DIV/DIVU/REM/REMU (and W-variants) from issue, hands operand
// magnitudes to the core, applies sign/word fix-ups and holds the result for
// writeback under a valid/ready handshake. Handles flush and divide-by-zero.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            request handshake (in_ready only in IDLE)
//   in_a, in_b                   dividend / divisor
//   in_signed, in_rem, in_word   op decode: signed, remainder select, 32-bit op
//   flush                        kill in-flight or held op
//   out_valid/out_ready/out_data result handshake toward writeback
//   core_valid, core_a, core_b   start pulse and magnitudes to divider core
//   core_done, core_c            core finished/idle, {remainder, quotient}
//
// Optional build macro DIV_PAIR_CACHE_EN: keeps the last core quotient/remainder
// tagged by effective operands so a DIV/REM pair reuses one core pass.

module div_issue_unit #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned CORE_C_W = 2 * WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic                in_signed,
  input  logic                in_rem,
  input  logic                in_word,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                core_valid,
  output logic [WIDTH-1:0]    core_a,
  output logic [WIDTH-1:0]    core_b,
  input  logic                core_done,
  input  logic [CORE_C_W-1:0] core_c
);

  localparam int unsigned HW = WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE, S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             core_valid_q, core_valid_d;
  logic [WIDTH-1:0] core_a_q, core_a_d;
  logic [WIDTH-1:0] core_b_q, core_b_d;
  logic             op_rem_q, op_rem_d;
  logic             op_word_q, op_word_d;
  logic             neg_q_q, neg_q_d;     // quotient needs negation
  logic             neg_r_q, neg_r_d;     // remainder needs negation
  logic             drain_seen_q, drain_seen_d;

  logic [WIDTH-1:0] a_eff, b_eff, q_src, r_src;

`ifdef DIV_PAIR_CACHE_EN
  logic             op_signed_q, op_signed_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             from_cache_q, from_cache_d;
  logic             cache_valid_q, cache_valid_d;
  logic [WIDTH-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic             cache_signed_q, cache_signed_d;
  logic             cache_word_q, cache_word_d;
  logic [WIDTH-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
  logic             cache_hit;
`endif

  // Word ops use the low half, sign- or zero-extended per signedness.
  function automatic logic [WIDTH-1:0] eff_op(input logic [WIDTH-1:0] v,
                                              input logic s, input logic w);
    if (!w) return v;
    return s ? {{HW{v[HW-1]}}, v[HW-1:0]} : {{HW{1'b0}}, v[HW-1:0]};
  endfunction

  // |v| for signed ops; most-negative maps to 2^(WIDTH-1) as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Select quotient/remainder, restore sign, then word sign-extension.
  function automatic logic [WIDTH-1:0] fix_result(
      input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
      input logic nq, input logic nr, input logic rem, input logic word);
    logic [WIDTH-1:0] v;
    v = rem ? (nr ? (~r + WIDTH'(1)) : r) : (nq ? (~q + WIDTH'(1)) : q);
    if (word) v = {{HW{v[HW-1]}}, v[HW-1:0]};
    return v;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    core_valid_d = 1'b0;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    op_rem_d     = op_rem_q;
    op_word_d    = op_word_q;
    neg_q_d      = neg_q_q;
    neg_r_d      = neg_r_q;
    drain_seen_d = drain_seen_q;

    a_eff = eff_op(in_a, in_signed, in_word);
    b_eff = eff_op(in_b, in_signed, in_word);
    q_src = core_c[WIDTH-1:0];
    r_src = core_c[2*WIDTH-1:WIDTH];

`ifdef DIV_PAIR_CACHE_EN
    op_signed_d    = op_signed_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    from_cache_d   = from_cache_q;
    cache_valid_d  = cache_valid_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_signed_d = cache_signed_q;
    cache_word_d   = cache_word_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    cache_hit      = cache_valid_q && (cache_a_q == a_eff) && (cache_b_q == b_eff) &&
                     (cache_signed_q == in_signed) && (cache_word_q == in_word);
    if (from_cache_q) begin
      q_src = cache_quo_q;
      r_src = cache_rem_q;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_rem_d  = in_rem;
          op_word_d = in_word;
          neg_q_d   = in_signed & (a_eff[WIDTH-1] ^ b_eff[WIDTH-1]);
          neg_r_d   = in_signed & a_eff[WIDTH-1];
`ifdef DIV_PAIR_CACHE_EN
          op_signed_d = in_signed;
          op_a_d      = a_eff;
          op_b_d      = b_eff;
`endif
          if (b_eff == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            out_data_d = fix_result('1, a_eff, 1'b0, 1'b0, in_rem, in_word);
            state_d    = S_DONE;
`ifdef DIV_PAIR_CACHE_EN
          end else if (cache_hit) begin
            from_cache_d = 1'b1;
            state_d      = S_CAPTURE;
`endif
          end else begin
            core_a_d     = mag(a_eff, in_signed);
            core_b_d     = mag(b_eff, in_signed);
            core_valid_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush)          state_d = S_DRAIN;
        else if (core_done) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else begin
          out_data_d = fix_result(q_src, r_src, neg_q_q, neg_r_q, op_rem_q, op_word_q);
          state_d    = S_DONE;
`ifdef DIV_PAIR_CACHE_EN
          cache_valid_d  = 1'b1;
          cache_a_d      = op_a_q;
          cache_b_d      = op_b_q;
          cache_signed_d = op_signed_q;
          cache_word_d   = op_word_q;
          cache_quo_d    = q_src;
          cache_rem_d    = r_src;
`endif
        end
`ifdef DIV_PAIR_CACHE_EN
        from_cache_d = 1'b0;
`endif
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // One extra cycle after core_done so the core result bus settles.
        if (drain_seen_q) begin
          drain_seen_d = 1'b0;
          state_d      = S_IDLE;
        end else if (core_done) begin
          drain_seen_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DIV_PAIR_CACHE_EN
    if (state_d == S_DRAIN && state_q != S_DRAIN) cache_valid_d = 1'b0;
`endif
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      core_valid_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      op_rem_q     <= 1'b0;
      op_word_q    <= 1'b0;
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      drain_seen_q <= 1'b0;
`ifdef DIV_PAIR_CACHE_EN
      op_signed_q    <= 1'b0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      from_cache_q   <= 1'b0;
      cache_valid_q  <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 1'b0;
      cache_word_q   <= 1'b0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      core_valid_q <= core_valid_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      op_rem_q     <= op_rem_d;
      op_word_q    <= op_word_d;
      neg_q_q      <= neg_q_d;
      neg_r_q      <= neg_r_d;
      drain_seen_q <= drain_seen_d;
`ifdef DIV_PAIR_CACHE_EN
      op_signed_q    <= op_signed_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      from_cache_q   <= from_cache_d;
      cache_valid_q  <= cache_valid_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_signed_q <= cache_signed_d;
      cache_word_q   <= cache_word_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign core_valid = core_valid_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed testbench for div_issue_unit with a simple 5-cycle divider core model.
module tb_div_issue_unit;

  localparam int unsigned W = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           in_signed, in_rem, in_word;
  logic           flush;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic           core_valid;
  logic [W-1:0]   core_a, core_b;
  logic           core_done;
  logic [2*W-1:0] core_c;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [W-1:0] seen_a, seen_b;

  always #5 clk = ~clk;

  div_issue_unit #(.WIDTH(W), .CORE_C_W(2*W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_rem(in_rem), .in_word(in_word),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_valid(core_valid), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_c(core_c)
  );

  // Divider core model: busy for 5 cycles after a start pulse, idle reports done.
  logic           core_busy;
  int unsigned    core_cnt;
  logic [2*W-1:0] core_res;
  assign core_done = ~core_busy;
  assign core_c    = core_res;

  always @(posedge clk) begin
    if (reset) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      core_res  <= '0;
    end else if (core_valid) begin
      core_busy <= 1'b1;
      core_cnt  <= 5;
      core_res  <= (core_b == '0) ? '1 : {core_a % core_b, core_a / core_b};
    end else if (core_busy) begin
      if (core_cnt == 1) core_busy <= 1'b0;
      core_cnt <= core_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && core_valid) begin
      pulses = pulses + 1;
      seen_a = core_a;
      seen_b = core_b;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic r, input logic w);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("in_ready_before_op", W'(in_ready), W'(1));
    in_a = a; in_b = b; in_signed = s; in_rem = r; in_word = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat = number of cycles from the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    check("out_valid_timeout", W'(out_valid), W'(1));
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic r, input logic w, input logic [W-1:0] exp);
    int lat;
    start_op(a, b, s, r, w);
    wait_out(lat);
    check(tag, out_data, exp);
    release_out();
  endtask

  localparam logic [W-1:0] NEG7   = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [W-1:0] NEG2   = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [W-1:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINNEG = 64'h8000_0000_0000_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int p0;
    int n;
    logic saw_valid;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_rem = 1'b0; in_word = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_core_valid", W'(core_valid), W'(0));
    check("rst_core_a", core_a, '0);
    reset = 1'b0;
    @(negedge clk);

    // DIVU 100/7: accept, ISSUE, 5 core-busy cycles, WAIT sees done, CAPTURE, DONE.
    p0 = pulses;
    start_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    wait_out(lat);
    check("divu_100_7", out_data, 64'd14);
    check("divu_latency", W'(lat), W'(9));
    check("divu_pulses", W'(pulses - p0), W'(1));
    check("divu_core_a", seen_a, 64'd100);
    check("divu_core_b", seen_b, 64'd7);
    release_out();
    check("in_ready_after_release", W'(in_ready), W'(1));
    run_op("remu_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2);

    // Signed cases
    start_op(NEG7, 64'd2, 1'b1, 1'b0, 1'b0);
    wait_out(lat);
    check("div_m7_2", out_data, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_m7_core_a_mag", seen_a, 64'd7);
    release_out();
    run_op("rem_m7_2", NEG7, 64'd2, 1'b1, 1'b1, 1'b0, ONES);
    run_op("rem_7_m2", 64'd7, NEG2, 1'b1, 1'b1, 1'b0, 64'd1);

    // Overflow cases
    run_op("div_ovf", MINNEG, ONES, 1'b1, 1'b0, 1'b0, MINNEG);
    run_op("rem_ovf", MINNEG, ONES, 1'b1, 1'b1, 1'b0, 64'd0);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, ONES, 1'b1, 1'b0, 1'b1,
           64'hFFFF_FFFF_8000_0000);

    // Divide by zero: DONE one cycle after accept, core untouched.
    p0 = pulses;
    start_op(64'h1234, 64'd0, 1'b1, 1'b0, 1'b0);
    wait_out(lat);
    check("div_by0", out_data, ONES);
    check("div_by0_latency", W'(lat), W'(1));
    release_out();
    run_op("divu_by0", 64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, ONES);
    run_op("remw_by0", 64'h1234, 64'd0, 1'b1, 1'b1, 1'b1, 64'h1234);
    check("by0_no_core_pulse", W'(pulses - p0), W'(0));

    // Flush during WAIT
    start_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    saw_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin
      saw_valid = saw_valid | out_valid;
      @(negedge clk);
      n++;
    end
    saw_valid = saw_valid | out_valid;
    check("flush_no_out_valid", W'(saw_valid), W'(0));
    check("flush_in_ready_back", W'(in_ready), W'(1));
    run_op("divu_9_3_after_flush", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3);

    // Hold in DONE for 5 cycles
    start_op(64'd100, 64'd7, 1'b1, 1'b0, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_data", out_data, 64'd14);
      check("hold_in_ready", W'(in_ready), W'(0));
    end
    check("hold_out_valid", W'(out_valid), W'(1));
    release_out();

    // REM 100/7 directly after DIV 100/7
    p0 = pulses;
    start_op(64'd100, 64'd7, 1'b1, 1'b1, 1'b0);
    wait_out(lat);
    check("rem_pair", out_data, 64'd2);
`ifdef DIV_PAIR_CACHE_EN
    check("rem_pair_pulses", W'(pulses - p0), W'(0));
    check("rem_pair_latency", W'(lat), W'(2));
`else
    check("rem_pair_pulses", W'(pulses - p0), W'(1));
    check("rem_pair_latency", W'(lat), W'(9));
`endif
    release_out();

    // Flush and out_ready together in DONE: result dropped.
    start_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0);
    wait_out(lat);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush_done_out_valid", W'(out_valid), W'(0));
    check("flush_done_in_ready", W'(in_ready), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
